// File: rtl/cache_types_pkg.sv
// Shared types for the L1 cache controller: FSM states and datapath mux encodings.
package cache_types_pkg;

    typedef enum logic [1:0] {
        HIT_CHECK = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } cache_state_e;

    localparam logic [1:0] ADDR_CPU  = 2'b00;
    localparam logic [1:0] ADDR_WAY0 = 2'b01;
    localparam logic [1:0] ADDR_WAY1 = 2'b10;

    localparam logic DIN_CPU  = 1'b0;
    localparam logic DIN_PMEM = 1'b1;

    function automatic logic [1:0] way_addr_sel(input logic way);
        return way ? ADDR_WAY1 : ADDR_WAY0;
    endfunction

endpackage

// File: rtl/cache_control_if.sv
// CPU-side and physical-memory-side handshakes of the cache controller.
interface cache_control_if;
    logic cmem_read;
    logic cmem_write;
    logic cmem_resp;
    logic pmem_resp;
    logic pmem_read;
    logic pmem_write;

    modport master (output cmem_read, cmem_write, pmem_resp,
                    input  cmem_resp, pmem_read, pmem_write);
    modport slave  (input  cmem_read, cmem_write, pmem_resp,
                    output cmem_resp, pmem_read, pmem_write);
endinterface

// File: rtl/cache_perf_counter.sv
// Saturating up-counter with enable and synchronous clear.
module cache_perf_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [WIDTH-1:0] count
);
    always_ff @(posedge clk) begin
        if (rst)
            count <= '0;
        else if (en && (count != '1))
            count <= count + 1'b1;
    end
endmodule

// File: rtl/cache_control.sv
// Control FSM for the 2-way write-back/write-allocate L1 cache.
// Optional performance counters are built when CACHE_PERF_CNT_EN is defined.
module cache_control
    import cache_types_pkg::*;
#(
    parameter int CNT_WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    cache_control_if.slave     bus,
    input  logic               hit0,
    input  logic               hit1,
    input  logic               dirty0,
    input  logic               dirty1,
    input  logic               lru_out,
    output logic               load_valid0,
    output logic               load_valid1,
    output logic               load_dirty0,
    output logic               load_dirty1,
    output logic               load_tag0,
    output logic               load_tag1,
    output logic               load_data0,
    output logic               load_data1,
    output logic               load_lru,
    output logic               lru_in,
    output logic               dirty_in,
    output logic [1:0]         addr_sel,
    output logic               datain_sel
`ifdef CACHE_PERF_CNT_EN
   ,output logic [CNT_WIDTH-1:0] hit_count,
    output logic [CNT_WIDTH-1:0] miss_count,
    output logic [CNT_WIDTH-1:0] wb_count
`endif
);
    cache_state_e state, next_state;
    logic [1:0]   ld_valid, ld_dirty, ld_tag, ld_data;
    logic         cmem_resp, pmem_read, pmem_write;
    logic         req, is_write, hit, hit_way, victim, victim_dirty;

    // A simultaneous read+write is served as a write; way0 wins a double hit.
    assign req          = bus.cmem_read | bus.cmem_write;
    assign is_write     = bus.cmem_write;
    assign hit          = hit0 | hit1;
    assign hit_way      = ~hit0;
    assign victim       = lru_out;
    assign victim_dirty = victim ? dirty1 : dirty0;

    always_ff @(posedge clk) begin
        if (rst) state <= HIT_CHECK;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        ld_valid   = '0;
        ld_dirty   = '0;
        ld_tag     = '0;
        ld_data    = '0;
        load_lru   = 1'b0;
        lru_in     = 1'b0;
        dirty_in   = 1'b0;
        addr_sel   = ADDR_CPU;
        datain_sel = DIN_CPU;
        cmem_resp  = 1'b0;
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        if (rst) begin
            next_state = HIT_CHECK;
        end else begin
            case (state)
                HIT_CHECK: begin
                    if (req && hit) begin
                        cmem_resp = 1'b1;
                        load_lru  = 1'b1;
                        lru_in    = ~hit_way;
                        if (is_write) begin
                            ld_data[hit_way]  = 1'b1;
                            ld_dirty[hit_way] = 1'b1;
                            dirty_in          = 1'b1;
                            datain_sel        = DIN_CPU;
                        end
                    end else if (req) begin
                        next_state = victim_dirty ? WRITEBACK : ALLOCATE;
                    end
                end
                WRITEBACK: begin
                    pmem_write = 1'b1;
                    addr_sel   = way_addr_sel(victim);
                    if (bus.pmem_resp) next_state = ALLOCATE;
                end
                ALLOCATE: begin
                    pmem_read = 1'b1;
                    addr_sel  = ADDR_CPU;
                    if (bus.pmem_resp) begin
                        ld_data[victim]  = 1'b1;
                        ld_tag[victim]   = 1'b1;
                        ld_valid[victim] = 1'b1;
                        ld_dirty[victim] = 1'b1;
                        dirty_in         = 1'b0;
                        datain_sel       = DIN_PMEM;
                        next_state       = HIT_CHECK;
                    end
                end
                default: next_state = HIT_CHECK;
            endcase
        end
    end

    assign bus.cmem_resp  = cmem_resp;
    assign bus.pmem_read  = pmem_read;
    assign bus.pmem_write = pmem_write;
    assign {load_valid1, load_valid0} = ld_valid;
    assign {load_dirty1, load_dirty0} = ld_dirty;
    assign {load_tag1,   load_tag0}   = ld_tag;
    assign {load_data1,  load_data0}  = ld_data;

`ifdef CACHE_PERF_CNT_EN
    // Set while the pending request has already missed, so its final hit is not counted.
    logic retry;
    logic hit_inc, miss_inc, wb_inc;

    always_ff @(posedge clk) begin
        if (rst)
            retry <= 1'b0;
        else if (state == HIT_CHECK && next_state != HIT_CHECK)
            retry <= 1'b1;
        else if (state == HIT_CHECK && (cmem_resp || !req))
            retry <= 1'b0;
    end

    assign hit_inc  = (state == HIT_CHECK) && cmem_resp && !retry;
    assign miss_inc = (state == HIT_CHECK) && (next_state != HIT_CHECK);
    assign wb_inc   = (state == WRITEBACK) && (next_state != WRITEBACK);

    cache_perf_counter #(.WIDTH(CNT_WIDTH)) u_hit_cnt
        (.clk(clk), .rst(rst), .en(hit_inc),  .count(hit_count));
    cache_perf_counter #(.WIDTH(CNT_WIDTH)) u_miss_cnt
        (.clk(clk), .rst(rst), .en(miss_inc), .count(miss_count));
    cache_perf_counter #(.WIDTH(CNT_WIDTH)) u_wb_cnt
        (.clk(clk), .rst(rst), .en(wb_inc),   .count(wb_count));
`else
    localparam int unused_cnt_width = CNT_WIDTH;
`endif

endmodule
